// File: rtl/input_port.sv
// Synchronised, debounced switch-bank input port for the picoMIPS datapath.
// A debounced button press captures the switches; the CPU read strobe acknowledges the capture.
module input_port #(
    parameter int unsigned WIDTH           = 8,
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             n_reset,
    input  logic [WIDTH-1:0] sw,
    input  logic             btn,
    input  logic             rd,
    output logic [WIDTH-1:0] data,
    output logic             valid
);

    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StHold, StRelease} state_e;

    logic [WIDTH-1:0] sw_meta, sw_s;
    logic             btn_meta, btn_s;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             btn_db, btn_db_d, btn_db_q;
    logic             press;
    state_e           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            sw_meta  <= '0;
            sw_s     <= '0;
            btn_meta <= 1'b0;
            btn_s    <= 1'b0;
            cnt_q    <= '0;
            btn_db   <= 1'b0;
            btn_db_q <= 1'b0;
            state_q  <= StIdle;
            data_q   <= '0;
        end else begin
            sw_meta  <= sw;
            sw_s     <= sw_meta;
            btn_meta <= btn;
            btn_s    <= btn_meta;
            cnt_q    <= cnt_d;
            btn_db   <= btn_db_d;
            btn_db_q <= btn_db;
            state_q  <= state_d;
            data_q   <= data_d;
        end
    end

    // The level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_comb begin
        cnt_d    = '0;
        btn_db_d = btn_db;
        if (btn_s != btn_db) begin
            if (cnt_q == CntMax) begin
                btn_db_d = ~btn_db;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign press = btn_db & ~btn_db_q;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        case (state_q)
            StIdle: begin
                if (press) begin
                    data_d  = sw_s;
                    state_d = StHold;
                end
            end
            StHold: begin
                if (rd) begin
                    state_d = StRelease;
                end
            end
            // Wait for the button to come up so one long press gives one capture.
            StRelease: begin
                if (!btn_db) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign data  = data_q;
    assign valid = (state_q == StHold);

endmodule

// File: tb/tb_input_port.sv
// Self-checking bench for input_port: directed scenarios plus randomized button/switch/rd
// traffic compared every cycle against a behavioural model.
module tb_input_port;

    localparam int unsigned W = 8;
    localparam int unsigned D = 4;

    bit           clk = 1'b0;
    logic         n_reset = 1'b0;
    logic [W-1:0] sw = '0;
    logic         btn = 1'b0;
    logic         rd = 1'b0;
    logic [W-1:0] data;
    logic         valid;

    int n_checks = 0;
    int n_errors = 0;

    input_port #(
        .WIDTH          (W),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk    (clk),
        .n_reset(n_reset),
        .sw     (sw),
        .btn    (btn),
        .rd     (rd),
        .data   (data),
        .valid  (valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Behavioural model: pins reach the debouncer two edges late; the debounced level
    // flips once the last D samples since the previous flip all disagree with it.
    logic [W-1:0] m_sw_meta, m_sw_s, m_data;
    logic         m_b_meta, m_b_s, m_db, m_db_prev;
    bit           m_hist[$];
    int           m_since;
    int           m_mode;      // 0 waiting for press, 1 holding, 2 waiting for release
    logic         m_valid;

    assign m_valid = (m_mode == 1);

    always @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            m_sw_meta = '0; m_sw_s = '0; m_b_meta = 0; m_b_s = 0;
            m_db = 0; m_db_prev = 0; m_hist.delete(); m_since = 0;
            m_mode = 0; m_data = '0;
        end else begin
            logic [W-1:0] sw_used;
            logic         b_used, pressed, db_before, flip;
            sw_used   = m_sw_s;
            b_used    = m_b_s;
            m_sw_s    = m_sw_meta;
            m_sw_meta = sw;
            m_b_s     = m_b_meta;
            m_b_meta  = btn;
            db_before = m_db;
            pressed   = m_db && !m_db_prev;
            case (m_mode)
                0: if (pressed) begin m_data = sw_used; m_mode = 1; end
                1: if (rd) m_mode = 2;
                default: if (!db_before) m_mode = 0;
            endcase
            m_hist.push_back(b_used);
            if (m_hist.size() > D) void'(m_hist.pop_front());
            m_since++;
            flip = (m_since >= D);
            foreach (m_hist[j]) if (m_hist[j] == m_db) flip = 0;
            m_db_prev = m_db;
            if (flip) begin
                m_db    = !m_db;
                m_since = 0;
            end
        end
    end

    always @(negedge clk) begin
        check("model_data", data, m_data);
        check("model_valid", valid, m_valid);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        n_reset = 0; sw = 8'hFF; btn = 0; rd = 0;
        tick(3);
        check("rst_data", data, 8'h00);
        check("rst_valid", valid, 0);
        n_reset = 1;
        tick(20);
        check("idle_data", data, 8'h00);
        check("idle_valid", valid, 0);

        // Clean press: valid rises exactly D+3 edges after the button.
        sw = 8'hA5; btn = 1;
        for (int k = 1; k <= D + 3; k++) begin
            tick(1);
            check("press_valid", valid, (k == D + 3));
        end
        check("press_data", data, 8'hA5);
        rd = 1; tick(1); rd = 0;
        check("rd_valid", valid, 0);
        check("rd_data", data, 8'hA5);
        btn = 0; tick(D + 4);

        // Glitch shorter than D cycles.
        sw = 8'h3C; btn = 1; tick(D - 1); btn = 0;
        for (int k = 0; k < 30; k++) begin
            tick(1);
            check("glitch_valid", valid, 0);
        end
        check("glitch_data", data, 8'hA5);

        // Long press gives a single capture.
        sw = 8'h11; btn = 1; tick(D + 3);
        check("long_valid", valid, 1);
        check("long_data", data, 8'h11);
        rd = 1; tick(1); rd = 0; sw = 8'h22;
        tick(20);
        check("long_nocap_valid", valid, 0);
        check("long_nocap_data", data, 8'h11);
        btn = 0; tick(D + 4);
        btn = 1; tick(D + 3);
        check("repress_valid", valid, 1);
        check("repress_data", data, 8'h22);
        rd = 1; tick(1); rd = 0; btn = 0; tick(D + 4);

        // rd in IDLE is ignored; rd coinciding with capture does not drop valid.
        rd = 1; tick(10);
        check("rd_idle_valid", valid, 0);
        sw = 8'h5A; btn = 1; tick(D + 3);
        check("rd_cap_valid", valid, 1);
        check("rd_cap_data", data, 8'h5A);
        tick(1);
        check("rd_hold_valid", valid, 0);
        rd = 0; btn = 0; tick(D + 4);

        // Asynchronous reset while holding, button kept pressed through release.
        sw = 8'h77; btn = 1; tick(D + 3);
        check("hold_valid", valid, 1);
        check("hold_data", data, 8'h77);
        #2 n_reset = 0;
        #1;
        check("async_rst_valid", valid, 0);
        check("async_rst_data", data, 8'h00);
        tick(1);
        n_reset = 1;
        tick(D + 2);
        check("post_rst_early_valid", valid, 0);
        tick(1);
        check("post_rst_valid", valid, 1);
        check("post_rst_data", data, 8'h77);
        rd = 1; tick(1); rd = 0; btn = 0; tick(D + 4);

        // Randomized traffic, checked every cycle against the model.
        for (int i = 0; i < 3000; i++) begin
            sw = W'($urandom);
            if ($urandom_range(0, 7) == 0) btn = ~btn;
            rd = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 399) == 0) begin
                #2 n_reset = 0;
                tick(1);
                n_reset = 1;
            end else begin
                tick(1);
            end
        end
        tick(2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
